// File: rtl/axil_rr_arbiter_if.sv
// axil_rr_arbiter_if: AXI4-Lite bundle (no BRESP) shared by the arbiter's slave and master ports.
interface axil_rr_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_rr_arbiter.sv
// axil_rr_arbiter: 2:1 round-robin AXI4-Lite arbiter, one whole transaction per grant, W never leads AW.
module axil_rr_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                aclk,
    input  logic                aresetn,
    axil_rr_arbiter_if.slave    s0,
    axil_rr_arbiter_if.slave    s1,
    axil_rr_arbiter_if.master   m,
    output logic [1:0]          grant,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t state, state_nx;
    logic   owner, owner_nx, last_owner, last_owner_nx;
    logic   aw_done, aw_done_nx, w_done, w_done_nx;

    logic [ADDR_WIDTH-1:0] awaddr_o, araddr_o;
    logic [DATA_WIDTH-1:0] wdata_o;
    logic [STRB_WIDTH-1:0] wstrb_o;
    logic [2:0]            awprot_o, arprot_o;
    logic awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o;
    logic wr, rd, sel0, sel1, req0, req1, pick;
    logic aw_hs, w_ok, w_hs, b_ok, b_hs, r_hs;

    assign wr    = state == WR;
    assign rd    = state == RD;
    assign busy  = state != IDLE;
    assign sel0  = busy & !owner;
    assign sel1  = busy & owner;
    assign grant = {sel1, sel0};
    assign req0  = s0.arvalid | s0.awvalid;
    assign req1  = s1.arvalid | s1.awvalid;
    assign pick  = (req0 & req1) ? !last_owner : req1;

    always_comb begin
        awaddr_o  = owner ? s1.awaddr  : s0.awaddr;
        awprot_o  = owner ? s1.awprot  : s0.awprot;
        awvalid_o = owner ? s1.awvalid : s0.awvalid;
        wdata_o   = owner ? s1.wdata   : s0.wdata;
        wstrb_o   = owner ? s1.wstrb   : s0.wstrb;
        wvalid_o  = owner ? s1.wvalid  : s0.wvalid;
        bready_o  = owner ? s1.bready  : s0.bready;
        araddr_o  = owner ? s1.araddr  : s0.araddr;
        arprot_o  = owner ? s1.arprot  : s0.arprot;
        arvalid_o = owner ? s1.arvalid : s0.arvalid;
        rready_o  = owner ? s1.rready  : s0.rready;
    end

    // W may only pass in the same cycle as, or after, the AW handshake
    assign aw_hs = m.awvalid & m.awready;
    assign w_ok  = wr & !w_done & (aw_done | aw_hs);
    assign w_hs  = m.wvalid & m.wready;
    assign b_ok  = wr & aw_done & w_done;
    assign b_hs  = m.bvalid & m.bready;
    assign r_hs  = m.rvalid & m.rready;

    assign m.awaddr  = wr ? awaddr_o : '0;
    assign m.awprot  = wr ? awprot_o : '0;
    assign m.awvalid = wr & awvalid_o & !aw_done;
    assign m.wdata   = wr ? wdata_o : '0;
    assign m.wstrb   = wr ? wstrb_o : '0;
    assign m.wvalid  = w_ok & wvalid_o;
    assign m.bready  = b_ok & bready_o;
    assign m.araddr  = rd ? araddr_o : '0;
    assign m.arprot  = rd ? arprot_o : '0;
    assign m.arvalid = rd & arvalid_o;
    assign m.rready  = rd & rready_o;

    assign s0.awready = sel0 & wr & !aw_done & m.awready;
    assign s0.wready  = sel0 & w_ok & m.wready;
    assign s0.bvalid  = sel0 & b_ok & m.bvalid;
    assign s0.arready = sel0 & rd & m.arready;
    assign s0.rvalid  = sel0 & rd & m.rvalid;
    assign s0.rdata   = (sel0 & rd) ? m.rdata : '0;
    assign s0.rresp   = (sel0 & rd) ? m.rresp : '0;

    assign s1.awready = sel1 & wr & !aw_done & m.awready;
    assign s1.wready  = sel1 & w_ok & m.wready;
    assign s1.bvalid  = sel1 & b_ok & m.bvalid;
    assign s1.arready = sel1 & rd & m.arready;
    assign s1.rvalid  = sel1 & rd & m.rvalid;
    assign s1.rdata   = (sel1 & rd) ? m.rdata : '0;
    assign s1.rresp   = (sel1 & rd) ? m.rresp : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_owner_nx;
            aw_done    <= aw_done_nx;
            w_done     <= w_done_nx;
        end
    end

    // a write request outranks a read from the same master
    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_owner_nx = last_owner;
        aw_done_nx    = aw_done | aw_hs;
        w_done_nx     = w_done | w_hs;
        case (state)
            IDLE: begin
                aw_done_nx = 1'b0;
                w_done_nx  = 1'b0;
                if (req0 | req1) begin
                    owner_nx = pick;
                    state_nx = (pick ? s1.awvalid : s0.awvalid) ? WR : RD;
                end
            end
            RD: if (r_hs) begin
                last_owner_nx = owner;
                state_nx      = IDLE;
            end
            WR: if (b_hs) begin
                last_owner_nx = owner;
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axil_rr_arbiter.sv
// tb_axil_rr_arbiter: directed + random bench with a memory responder, arbitration rule model and reference memory.
module tb_axil_rr_arbiter;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    axil_rr_arbiter_if s_if[2] ();
    axil_rr_arbiter_if m_if ();
    logic [1:0] grant;
    logic       busy;

    axil_rr_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0(s_if[0]), .s1(s_if[1]), .m(m_if),
        .grant(grant), .busy(busy)
    );

    logic [1:0]  awvalid = '0, wvalid = '0, bready = '0, arvalid = '0, rready = '0;
    logic [31:0] awaddr [2], wdata [2], araddr [2], rdata [2];
    logic [3:0]  wstrb [2];
    logic [1:0]  rresp [2];
    logic [1:0]  awready, wready, bvalid, arready, rvalid;

    for (genvar g = 0; g < 2; g++) begin : drv
        assign s_if[g].awaddr  = awaddr[g];
        assign s_if[g].awprot  = 3'(2 * g + 1);
        assign s_if[g].awvalid = awvalid[g];
        assign s_if[g].wdata   = wdata[g];
        assign s_if[g].wstrb   = wstrb[g];
        assign s_if[g].wvalid  = wvalid[g];
        assign s_if[g].bready  = bready[g];
        assign s_if[g].araddr  = araddr[g];
        assign s_if[g].arprot  = 3'(2 * g + 2);
        assign s_if[g].arvalid = arvalid[g];
        assign s_if[g].rready  = rready[g];
        assign awready[g] = s_if[g].awready;
        assign wready[g]  = s_if[g].wready;
        assign bvalid[g]  = s_if[g].bvalid;
        assign arready[g] = s_if[g].arready;
        assign rvalid[g]  = s_if[g].rvalid;
        assign rdata[g]   = s_if[g].rdata;
        assign rresp[g]   = s_if[g].rresp;
    end

    function automatic logic [31:0] init_word(input int i);
        return (i == 64) ? 32'hDEADBEEF : 32'h5A00_0000 ^ (i * 32'h0001_0101);
    endfunction

    // memory responder on the shared port, one outstanding read or write, random ready stalls
    logic [31:0] mem [256];
    logic        inited = 1'b0;
    logic        mem_stall = 1'b0;
    logic        aw_p, w_p;
    logic [31:0] aw_a, w_d;
    logic [3:0]  w_s, rnd;

    assign m_if.awready = !aw_p && !m_if.bvalid && rnd[1:0] != 2'b00;
    assign m_if.wready  = !w_p && !m_if.bvalid && rnd[3:2] != 2'b00;
    assign m_if.arready = !m_if.rvalid && !mem_stall && (rnd[1] || rnd[3]);
    assign m_if.rresp   = 2'b00;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_p <= 1'b0;
            w_p <= 1'b0;
            aw_a <= '0;
            w_d <= '0;
            w_s <= '0;
            rnd <= '0;
            m_if.bvalid <= 1'b0;
            m_if.rvalid <= 1'b0;
            m_if.rdata <= '0;
            if (!inited) begin
                for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
                inited <= 1'b1;
            end
        end else begin
            rnd <= 4'($urandom);
            if (m_if.awvalid && m_if.awready) begin
                aw_p <= 1'b1;
                aw_a <= m_if.awaddr;
            end
            if (m_if.wvalid && m_if.wready) begin
                w_p <= 1'b1;
                w_d <= m_if.wdata;
                w_s <= m_if.wstrb;
            end
            if (aw_p && w_p && !m_if.bvalid) begin
                for (int b = 0; b < 4; b++) if (w_s[b]) mem[aw_a[9:2]][8*b +: 8] <= w_d[8*b +: 8];
                aw_p <= 1'b0;
                w_p <= 1'b0;
                m_if.bvalid <= 1'b1;
            end
            if (m_if.bvalid && m_if.bready) m_if.bvalid <= 1'b0;
            if (m_if.arvalid && m_if.arready) begin
                m_if.rvalid <= 1'b1;
                m_if.rdata <= mem[m_if.araddr[9:2]];
            end else if (m_if.rvalid && m_if.rready) begin
                m_if.rvalid <= 1'b0;
                m_if.rdata <= $urandom;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] ref_mem [256];
    initial for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    // arbitration rule model and per-cycle bus rules
    logic [1:0] pg = '0, exp_g = '0, req;
    logic       last = 1'b1, pend = 1'b0, aw_seen = 1'b0, win;
    always @(negedge aclk) begin
        if (!aresetn) begin
            last = 1'b1;
            pend = 1'b0;
            pg = '0;
            aw_seen = 1'b0;
        end else begin
            if (pend) chk("arb_grant", grant, exp_g);
            pend = 1'b0;
            if (pg != 2'b00 && grant == 2'b00) last = pg[1];
            req = arvalid | awvalid;
            if (grant == 2'b00 && req != 2'b00) begin
                win = (req == 2'b11) ? !last : req[1];
                exp_g = win ? 2'b10 : 2'b01;
                pend = 1'b1;
            end
            chk("busy", busy, grant != 2'b00);
            chk("nonowner_quiet", {rvalid & ~grant, bvalid & ~grant, arready & ~grant, awready & ~grant, wready & ~grant}, '0);
            for (int p = 0; p < 2; p++) if (!grant[p]) chk("nonowner_rdata", {rresp[p], rdata[p]}, '0);
            if (grant == 2'b00) chk("idle_quiet", {m_if.awvalid, m_if.wvalid, m_if.arvalid, m_if.rready, m_if.bready}, '0);
            chk("w_after_aw", m_if.wvalid & !(aw_seen | (m_if.awvalid & m_if.awready)), 1'b0);
            if (m_if.awvalid && m_if.awready) aw_seen = 1'b1;
            if (m_if.bvalid && m_if.bready) aw_seen = 1'b0;
            pg = grant;
        end
    end

    task automatic rd(input int p, input logic [31:0] a, output int ar_cyc, output logic [31:0] d);
        bit arf, rf, done;
        done = 0;
        ar_cyc = 0;
        d = '0;
        araddr[p] = a;
        arvalid[p] = 1'b1;
        rready[p] = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge aclk);
            arf = arvalid[p] & arready[p];
            rf = rvalid[p] & rready[p];
            if (rf) d = rdata[p];
            if (arf) begin
                chk("ar_pass", {m_if.arprot, m_if.araddr}, {3'(2 * p + 2), a});
                ar_cyc = cyc;
            end
            @(posedge aclk);
            #1;
            if (arf) arvalid[p] = 1'b0;
            if (rf) begin
                rready[p] = 1'b0;
                done = 1;
            end
        end
        if (!done) begin
            chk("rd_timeout", 1'b0, 1'b1);
            arvalid[p] = 1'b0;
            rready[p] = 1'b0;
        end else chk("rd_data", d, ref_mem[a[9:2]]);
    endtask

    task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int lead, input int hold, output int b_cyc);
        bit awf, wf, bf, done, bseen;
        int h;
        done = 0;
        bseen = 0;
        h = hold;
        b_cyc = 0;
        awaddr[p] = a;
        wdata[p] = d;
        wstrb[p] = s;
        wvalid[p] = 1'b1;
        bready[p] = (hold == 0);
        for (int i = 0; i < lead; i++) begin
            @(negedge aclk);
            chk("w_lead_blocked", wready[p], 1'b0);
            @(posedge aclk);
            #1;
        end
        awvalid[p] = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge aclk);
            awf = awvalid[p] & awready[p];
            wf = wvalid[p] & wready[p];
            bf = bvalid[p] & bready[p];
            if (awf) chk("aw_pass", {m_if.awprot, m_if.awaddr}, {3'(2 * p + 1), a});
            if (wf) chk("w_pass", {m_if.wstrb, m_if.wdata}, {s, d});
            if (!bready[p] && (bseen || bvalid[p])) begin
                bseen = 1;
                chk("b_held", {bvalid[p], grant}, {1'b1, (p == 1) ? 2'b10 : 2'b01});
                h--;
            end
            if (bf) b_cyc = cyc;
            @(posedge aclk);
            #1;
            if (awf) awvalid[p] = 1'b0;
            if (wf) wvalid[p] = 1'b0;
            if (bf) begin
                bready[p] = 1'b0;
                done = 1;
            end else if (bseen && h <= 0) bready[p] = 1'b1;
        end
        if (!done) begin
            chk("wr_timeout", 1'b0, 1'b1);
            awvalid[p] = 1'b0;
            wvalid[p] = 1'b0;
            bready[p] = 1'b0;
        end else
            for (int b = 0; b < 4; b++) if (s[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic rand_op(input int p);
        int c;
        logic [31:0] a, d;
        repeat ($urandom_range(0, 2)) @(posedge aclk);
        #1;
        a = 32'((p * 128 + int'($urandom_range(0, 7))) * 4);
        if ($urandom_range(0, 1) == 1) rd(p, a, c, d);
        else wr(p, a, $urandom, 4'($urandom_range(1, 15)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), c);
    endtask

    task automatic first_grant(input string tag, input logic [1:0] exp);
        int i;
        i = 0;
        do @(negedge aclk); while (grant == 2'b00 && ++i < 50);
        chk(tag, grant, exp);
    endtask

    function automatic logic [31:0] quiet_vec();
        return {grant, busy, m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready,
                awready, wready, bvalid, arready, rvalid};
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, c1;
        logic [31:0] d0, d1, old;
        for (int p = 0; p < 2; p++) begin
            awaddr[p] = '0; wdata[p] = '0; araddr[p] = '0; wstrb[p] = '0;
        end
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset_state", quiet_vec(), '0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk);
        #1;

        rd(0, 32'h100, c0, d0);
        chk("t1_data", d0, 32'hDEADBEEF);
        rd(1, 32'h200, c1, d1);

        for (int r = 0; r < 4; r++) begin
            fork
                rd(0, 32'(16 + 4 * r), c0, d0);
                rd(1, 32'(528 + 4 * r), c1, d1);
                first_grant("rr_first", 2'b01);
            join
            chk("rr_order", c1 > c0, 1'b1);
        end

        old = ref_mem[16];
        wr(1, 32'h40, 32'h12345678, 4'b0011, 2, 0, c1);
        rd(1, 32'h40, c0, d0);
        chk("t3_strb", d0, {old[31:16], 16'h5678});

        fork
            wr(0, 32'h80, 32'hA1B2C3D4, 4'b1111, 0, 0, c0);
            rd(0, 32'h80, c1, d0);
        join
        chk("t4_write_first", c1 >= c0 + 2, 1'b1);
        chk("t4_data", d0, 32'hA1B2C3D4);

        fork
            wr(0, 32'hC0, 32'hCAFEF00D, 4'b1111, 0, 5, c0);
            begin
                @(posedge aclk);
                #1;
                rd(1, 32'h204, c1, d1);
            end
        join
        chk("t6_s1_waits", c1 > c0, 1'b1);

        mem_stall = 1'b1;
        araddr[0] = 32'h100;
        arvalid[0] = 1'b1;
        rready[0] = 1'b1;
        for (int i = 0; i < 50 && grant != 2'b01; i++) @(posedge aclk);
        @(posedge aclk);
        #3 aresetn = 1'b0;
        #1 chk("t5_async_reset", quiet_vec(), '0);
        arvalid[0] = 1'b0;
        rready[0] = 1'b0;
        mem_stall = 1'b0;
        repeat (2) @(posedge aclk);
        #3 aresetn = 1'b1;
        fork
            rd(0, 32'h104, c0, d0);
            rd(1, 32'h208, c1, d1);
            first_grant("t5_tie_after_reset", 2'b01);
        join

        for (int it = 0; it < 40; it++) begin
            fork
                rand_op(0);
                rand_op(1);
            join
        end

        repeat (3) @(posedge aclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
